adc_spi_responder: RTL and testbench

- Synthesizable model of the 12-bit, 8-channel SPI ADC that our SPI master drives. It is the far end of the CONVST/SCK/SDI/SDO link.
- Accepts a 6-bit config word on SDI and performs a timed conversion on each CONVST rising edge. It then shifts the 12-bit result out on SDO, MSB first.
- Used as the device-under-control in system simulation and in loopback builds on the FPGA, where real channel samples come from `ch_data`.

---
 rtl/adc_spi_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//    Synthesizable model of the 12-bit, 8-channel SPI ADC at the far end of
//    the CONVST/SCK/SDI/SDO link. A CONVST rise samples the selected channel
//    and runs a timed conversion. The following SCK frame then shifts the
//    result out on SDO (MSB first, driven on falling edges) and takes a new
//    config word in from SDI (MSB first, sampled on the first CFG_W rising edges).
//
// Ports
//    clk        system clock
//    reset_n    asynchronous active-low reset
//    convst     conversion start; the rising edge is the event
//    spi_scl    SPI clock from the master, idles high
//    spi_sdi    config bits from the master
//    spi_sdo    result bits to the master
//    ch_data    packed channel samples, channel c at [c*DATA_W +: DATA_W]
//    busy       high while converting
//    cfg_word   last complete config word; top bits select the channel
//    cfg_valid  one-cycle pulse when cfg_word updates
//    frame_err  one-cycle pulse on a protocol violation
//    o_state    current FSM state (debug)
module adc_spi_responder #(
   parameter int DATA_W      = 12,
   parameter int CFG_W       = 6,
   parameter int NUM_CH      = 8,
   parameter int CONV_CYCLES = 80
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       convst,
   input  logic                       spi_scl,
   input  logic                       spi_sdi,
   output logic                       spi_sdo,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data,
   output logic                       busy,
   output logic [CFG_W-1:0]           cfg_word,
   output logic                       cfg_valid,
   output logic                       frame_err,
   output logic [2:0]                 o_state
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(CONV_CYCLES);
   localparam int BIT_W = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_W);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] CFG_BITS = BIT_W'(CFG_W);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONVERT = 3'd1,
      ST_READY   = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cv_sync_q, scl_sync_q;   // [0] first stage, [2] edge reference
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [DATA_W-1:0]   result_q, result_d;      // shifted left as bits leave
   logic [BIT_W-1:0]    fall_cnt_q, fall_cnt_d;
   logic [BIT_W-1:0]    rise_cnt_q, rise_cnt_d;
   logic [CFG_W-1:0]    cfg_sh_q, cfg_sh_d;
   logic [CFG_W-1:0]    cfg_word_q, cfg_word_d;
   logic                cfg_valid_q, cfg_valid_d;
   logic                frame_err_q, frame_err_d;
   logic                sdo_q, sdo_d;
   logic                busy_q, busy_d;

   logic                cv_rise_s, scl_rise_s, scl_fall_s;
   logic [SEL_W-1:0]    sel_s;
   logic [DATA_W-1:0]   ch_arr_s [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_arr_s[c] = ch_data[c*DATA_W +: DATA_W];
   end

   assign sel_s      = cfg_word_q[CFG_W-1 -: SEL_W];
   assign cv_rise_s  =  cv_sync_q[1]  & ~cv_sync_q[2];
   assign scl_rise_s =  scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall_s = ~scl_sync_q[1] &  scl_sync_q[2];

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a convst rise outside CONVERT always wins over SCK.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (cv_rise_s) state_d = ST_CONVERT;
            else           state_d = state_q;
         end
         ST_CONVERT: begin
            if (cnt_q == CNT_ZERO) state_d = ST_READY;
            else                   state_d = ST_CONVERT;
         end
         ST_READY: begin
            if (cv_rise_s)       state_d = ST_CONVERT;
            else if (scl_fall_s) state_d = ST_SHIFT;
            else                 state_d = ST_READY;
         end
         ST_SHIFT: begin
            if (cv_rise_s)                                 state_d = ST_CONVERT;
            else if (scl_rise_s && rise_cnt_q == BIT_LAST) state_d = ST_DONE;
            else                                           state_d = ST_SHIFT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and next values of the registered outputs.
   always_comb begin
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      result_d    = result_q;
      fall_cnt_d  = fall_cnt_q;
      rise_cnt_d  = rise_cnt_q;
      cfg_sh_d    = cfg_sh_q;
      cfg_word_d  = cfg_word_q;
      cfg_valid_d = 1'b0;
      frame_err_d = 1'b0;
      sdo_d       = sdo_q;
      busy_d      = busy_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            sdo_d = 1'b0;
            if (cv_rise_s) begin
               hold_d = ch_arr_s[sel_s];
               cnt_d  = CNT_LOAD;
               busy_d = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_CONVERT: begin
            // A second convst is flagged but neither restarts nor reloads.
            frame_err_d = cv_rise_s;
            if (cnt_q == CNT_ZERO) begin
               result_d   = hold_q;
               busy_d     = 1'b0;
               fall_cnt_d = BIT_ZERO;
               rise_cnt_d = BIT_ZERO;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_READY: begin
            if (cv_rise_s) begin
               frame_err_d = 1'b1;
               hold_d      = ch_arr_s[sel_s];
               cnt_d       = CNT_LOAD;
               busy_d      = 1'b1;
               sdo_d       = 1'b0;
            end else if (scl_fall_s) begin
               sdo_d      = result_q[DATA_W-1];
               result_d   = {result_q[DATA_W-2:0], 1'b0};
               fall_cnt_d = BIT_ONE;
            end else begin
               sdo_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (cv_rise_s) begin
               // Aborted frame: the partial config word is discarded.
               frame_err_d = 1'b1;
               hold_d      = ch_arr_s[sel_s];
               cnt_d       = CNT_LOAD;
               busy_d      = 1'b1;
               sdo_d       = 1'b0;
            end else begin
               if (scl_fall_s && (fall_cnt_q < BIT_MAX)) begin
                  sdo_d      = result_q[DATA_W-1];
                  result_d   = {result_q[DATA_W-2:0], 1'b0};
                  fall_cnt_d = fall_cnt_q + BIT_ONE;
               end else begin
                  fall_cnt_d = fall_cnt_q;
               end
               if (scl_rise_s) begin
                  if (rise_cnt_q < CFG_BITS) cfg_sh_d = {cfg_sh_q[CFG_W-2:0], spi_sdi};
                  else                       cfg_sh_d = cfg_sh_q;
                  rise_cnt_d = rise_cnt_q + BIT_ONE;
                  if (rise_cnt_q == BIT_LAST) begin
                     cfg_word_d  = cfg_sh_q;
                     cfg_valid_d = 1'b1;
                     sdo_d       = 1'b0;
                  end else begin
                     cfg_word_d = cfg_word_q;
                  end
               end else begin
                  rise_cnt_d = rise_cnt_q;
               end
            end
         end
         default: begin
            sdo_d  = 1'b0;
            busy_d = 1'b0;
         end
      endcase
   end

   // Synchronisers, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cv_sync_q   <= 3'b000;
         scl_sync_q  <= 3'b111;   // SCK idle level, so release is not seen as a fall
         cnt_q       <= CNT_ZERO;
         hold_q      <= {DATA_W{1'b0}};
         result_q    <= {DATA_W{1'b0}};
         fall_cnt_q  <= BIT_ZERO;
         rise_cnt_q  <= BIT_ZERO;
         cfg_sh_q    <= {CFG_W{1'b0}};
         cfg_word_q  <= {CFG_W{1'b0}};
         cfg_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         sdo_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cv_sync_q   <= {cv_sync_q[1:0], convst};
         scl_sync_q  <= {scl_sync_q[1:0], spi_scl};
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         result_q    <= result_d;
         fall_cnt_q  <= fall_cnt_d;
         rise_cnt_q  <= rise_cnt_d;
         cfg_sh_q    <= cfg_sh_d;
         cfg_word_q  <= cfg_word_d;
         cfg_valid_q <= cfg_valid_d;
         frame_err_q <= frame_err_d;
         sdo_q       <= sdo_d;
         busy_q      <= busy_d;
      end
   end

   assign spi_sdo   = sdo_q;
   assign busy      = busy_q;
   assign cfg_word  = cfg_word_q;
   assign cfg_valid = cfg_valid_q;
   assign frame_err = frame_err_q;
   assign o_state   = state_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Testbench for adc_spi_responder: directed scenarios plus randomized frames,
// checked every cycle against a behavioural model of the ADC protocol.
module tb_adc_spi_responder;
   localparam int DATA_W      = 12;
   localparam int CFG_W       = 6;
   localparam int NUM_CH      = 8;
   localparam int CONV_CYCLES = 80;
   localparam int ST_IDLE = 0, ST_CONVERT = 1, ST_READY = 2, ST_SHIFT = 3, ST_DONE = 4;

   logic                     clk, reset_n, convst, spi_scl, spi_sdi;
   logic                     spi_sdo, busy, cfg_valid, frame_err;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [CFG_W-1:0]         cfg_word;
   logic [2:0]               o_state;

   int n_checks = 0;
   int n_fail   = 0;

   adc_spi_responder #(
      .DATA_W(DATA_W), .CFG_W(CFG_W), .NUM_CH(NUM_CH), .CONV_CYCLES(CONV_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .convst(convst), .spi_scl(spi_scl),
      .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .ch_data(ch_data), .busy(busy),
      .cfg_word(cfg_word), .cfg_valid(cfg_valid), .frame_err(frame_err),
      .o_state(o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int chan_sample(input logic [NUM_CH*DATA_W-1:0] d, input int ch);
      logic [NUM_CH*DATA_W-1:0] t;
      t = d >> (DATA_W * ch);
      return int'(t[DATA_W-1:0]);
   endfunction

   // ---------------- behavioural model ----------------
   // Pin events become visible two clocks after the pin moves; the conversion
   // ends at an absolute cycle number; bits are computed arithmetically.
   int      m_state = 0, m_sdo = 0, m_busy = 0, m_valid = 0, m_err = 0;
   int      m_cfg = 0, m_acc = 0, m_hold = 0, m_result = 0, m_falls = 0, m_rises = 0;
   longint  cyc = 0, m_end = 0;
   logic [2:0] cv_h = 3'b000, sc_h = 3'b111;
   bit      ev_cv, ev_rise, ev_fall;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_state = ST_IDLE; m_sdo = 0; m_busy = 0; m_valid = 0; m_err = 0;
         m_cfg = 0; m_acc = 0; m_hold = 0; m_result = 0; m_falls = 0; m_rises = 0;
         cv_h = 3'b000; sc_h = 3'b111;
      end else begin
         ev_cv   =  cv_h[1] & ~cv_h[2];
         ev_rise =  sc_h[1] & ~sc_h[2];
         ev_fall = ~sc_h[1] &  sc_h[2];
         cv_h = {cv_h[1:0], convst};
         sc_h = {sc_h[1:0], spi_scl};
         cyc++;
         m_valid = 0;
         m_err   = 0;
         if (m_state == ST_CONVERT) begin
            if (ev_cv) m_err = 1;
            if (cyc == m_end) begin
               m_result = m_hold; m_busy = 0; m_state = ST_READY;
               m_falls = 0; m_rises = 0; m_acc = 0;
            end
         end else if (ev_cv) begin
            if (m_state == ST_READY || m_state == ST_SHIFT) m_err = 1;
            m_hold  = chan_sample(ch_data, m_cfg / 8);
            m_end   = cyc + CONV_CYCLES;
            m_busy  = 1; m_sdo = 0; m_state = ST_CONVERT;
         end else if (m_state == ST_READY && ev_fall) begin
            m_state = ST_SHIFT; m_falls = 1;
            m_sdo   = (m_result >> 11) & 1;
         end else if (m_state == ST_SHIFT) begin
            if (ev_fall && m_falls < 12) begin
               m_falls++;
               m_sdo = (m_result >> (12 - m_falls)) & 1;
            end
            if (ev_rise) begin
               m_rises++;
               if (m_rises <= 6) m_acc = m_acc * 2 + int'(spi_sdi);
               if (m_rises == 12) begin
                  m_cfg = m_acc; m_valid = 1; m_sdo = 0; m_state = ST_DONE;
               end
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check("sdo",       int'(spi_sdo),   m_sdo);
      check("busy",      int'(busy),      m_busy);
      check("cfg_word",  int'(cfg_word),  m_cfg);
      check("cfg_valid", int'(cfg_valid), m_valid);
      check("frame_err", int'(frame_err), m_err);
      check("state",     int'(o_state),   m_state);
   end

   // Pulse counters and busy run length, for the literal checks.
   int busy_run = 0, last_busy_run = 0, valid_cnt = 0, err_cnt = 0;
   always @(negedge clk) begin
      if (busy) busy_run++;
      else begin
         if (busy_run != 0) last_busy_run = busy_run;
         busy_run = 0;
      end
      valid_cnt += int'(cfg_valid);
      err_cnt   += int'(frame_err);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [DATA_W-1:0] v);
      logic [NUM_CH*DATA_W-1:0] m, w;
      m = {{(NUM_CH-1)*DATA_W{1'b0}}, {DATA_W{1'b1}}} << (DATA_W * c);
      w = {{(NUM_CH-1)*DATA_W{1'b0}}, v} << (DATA_W * c);
      ch_data = (ch_data & ~m) | w;
   endtask

   task automatic conv_pulse();
      convst = 1'b1; tick(2);
      convst = 1'b0; tick(2);
   endtask

   task automatic wait_not_busy();
      int n = 0;
      while (busy && n < 300) begin tick(1); n++; end
      check("busy_timeout", int'(n < 300), 1);
      tick(1);
   endtask

   // Master frame: nbits SCK cycles, SDI changes on falls, SDO sampled at rises.
   task automatic frame(input logic [CFG_W-1:0] cfg, input int nbits, input int half,
                        output logic [DATA_W-1:0] got);
      logic [CFG_W-1:0] sh;
      sh  = cfg;
      got = '0;
      for (int i = 0; i < nbits; i++) begin
         spi_scl = 1'b0;
         spi_sdi = (i < CFG_W) ? sh[CFG_W-1] : 1'($urandom_range(1, 0));
         sh      = {sh[CFG_W-2:0], 1'b0};
         tick(half);
         got     = {got[DATA_W-2:0], spi_sdo};
         spi_scl = 1'b1;
         tick(half);
      end
   endtask

   task automatic sck_toggle(input int half);
      for (int i = 0; i < 2; i++) begin
         spi_scl = 1'b0; spi_sdi = 1'($urandom_range(1, 0)); tick(half);
         spi_scl = 1'b1; tick(half);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [DATA_W-1:0] got;
      logic [CFG_W-1:0]  cur_cfg, cfg_r;
      int e0, v0, half, mode, exp_v;

      reset_n = 1'b0; convst = 1'b0; spi_scl = 1'b1; spi_sdi = 1'b0; ch_data = '0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         convst  = 1'($urandom_range(1, 0));
         spi_scl = 1'($urandom_range(1, 0));
         spi_sdi = 1'($urandom_range(1, 0));
         ch_data = {$urandom(), $urandom(), $urandom()};
      end
      check("rst_busy",  int'(busy),      0);
      check("rst_sdo",   int'(spi_sdo),   0);
      check("rst_cfg",   int'(cfg_word),  0);
      check("rst_state", int'(o_state),   ST_IDLE);
      check("rst_valid", int'(cfg_valid), 0);
      check("rst_err",   int'(frame_err), 0);
      convst = 1'b0; spi_scl = 1'b1; tick(2);
      reset_n = 1'b1; tick(3);

      // Latency and busy width, then basic read of channel 0.
      ch_data = '0; set_ch(0, 12'hA5C);
      convst = 1'b1; tick(2);
      check("busy_lat2", int'(busy), 0);
      tick(1);
      check("busy_lat3", int'(busy), 1);
      convst = 1'b0;
      wait_not_busy();
      check("busy_len", last_busy_run, CONV_CYCLES);
      frame(6'h00, 12, 5, got);
      check("basic_read", int'(got), 32'hA5C);
      tick(6);
      check("sdo_after", int'(spi_sdo), 0);
      check("done_state", int'(o_state), ST_DONE);

      // Config pipeline: channel 3 selected in frame 1 applies to conversion 2.
      set_ch(0, 12'hFFF); set_ch(3, 12'h123);
      conv_pulse(); wait_not_busy();
      v0 = valid_cnt;
      frame(6'b011_000, 12, 5, got);
      check("pipe_frame1", int'(got), 32'hFFF);
      check("pipe_valid",  valid_cnt - v0, 1);
      check("pipe_cfg",    int'(cfg_word), 32'h18);
      conv_pulse(); wait_not_busy();
      frame(6'h18, 12, 5, got);
      check("pipe_frame2", int'(got), 32'h123);

      // Abort after 5 falls.
      conv_pulse(); wait_not_busy();
      frame(6'h3F, 5, 5, got);
      set_ch(3, 12'h5A1);
      e0 = err_cnt;
      conv_pulse();
      check("abort_err",  err_cnt - e0, 1);
      check("abort_cfg",  int'(cfg_word), 32'h18);
      check("abort_busy", int'(busy), 1);
      wait_not_busy();
      frame(6'h18, 12, 5, got);
      check("abort_read", int'(got), 32'h5A1);

      // convst and SCK activity during CONVERT.
      set_ch(3, 12'h777);
      e0 = err_cnt;
      conv_pulse(); tick(4);
      sck_toggle(5);
      conv_pulse();
      check("conv_err", err_cnt - e0, 1);
      wait_not_busy();
      check("conv_busy_len", last_busy_run, CONV_CYCLES);
      check("conv_cfg", int'(cfg_word), 32'h18);
      frame(6'h18, 12, 5, got);
      check("conv_read", int'(got), 32'h777);

      // Asynchronous reset after 7 falls.
      set_ch(0, 12'h9E3); set_ch(3, 12'h246);
      conv_pulse(); wait_not_busy();
      frame(6'h18, 7, 5, got);
      #2 reset_n = 1'b0;
      #1;
      check("arst_sdo",   int'(spi_sdo),  0);
      check("arst_busy",  int'(busy),     0);
      check("arst_cfg",   int'(cfg_word), 0);
      check("arst_state", int'(o_state),  ST_IDLE);
      tick(2);
      spi_scl = 1'b1; convst = 1'b0; reset_n = 1'b1;
      tick(3);
      conv_pulse(); wait_not_busy();
      frame(6'h00, 12, 5, got);
      check("arst_read", int'(got), 32'h9E3);
      cur_cfg = 6'h00;

      // Randomized frames, aborts and mid-conversion restarts.
      for (int it = 0; it < 20; it++) begin
         ch_data = {$urandom(), $urandom(), $urandom()};
         half    = int'($urandom_range(7, 4));
         mode    = int'($urandom_range(2, 0));
         cfg_r   = 6'($urandom_range(63, 0));
         exp_v   = chan_sample(ch_data, int'(cur_cfg[5:3]));
         conv_pulse();
         if (mode == 2) begin
            tick(int'($urandom_range(20, 1)));
            sck_toggle(half);
            conv_pulse();
         end
         wait_not_busy();
         if (mode == 1) begin
            frame(cfg_r, int'($urandom_range(11, 0)), half, got);
            conv_pulse();
            wait_not_busy();
         end
         frame(cfg_r, 12, half, got);
         check("rand_read", int'(got), exp_v);
         check("rand_cfg",  int'(cfg_word), int'(cfg_r));
         cur_cfg = cfg_r;
      end

      tick(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
